idelay_eye_cal: RTL and testbench
=================================

Name: idelay_eye_cal

Overview:
- Multi-channel input-delay eye-centring controller.
- Sits above the per-lane variable-load delay sequencers and drives each lane's 9-bit tap load value in turn.
- For each lane it sweeps the taps, scores every tap with a training-pattern checker, finds the longest contiguous passing window and loads its centre.
- Lanes are calibrated one at a time, so only one delay line is moving at any instant.

Parameters:
- NUM_CH, 4: number of delay lanes controlled.
- TAP_W, 9: tap value width.
- TAP_MAX, 511: highest tap value swept.
- TAP_STEP, 8: tap increment per sweep point; sweep points are k*TAP_STEP ≤ TAP_MAX.
- SAMPLE_CNT, 256: valid samples scored per sweep point.
- SETTLE_IGN, 2: cycles after a tap write during which dly_done is ignored.
- TIMEOUT, 4096: maximum cycles to wait for dly_done after a tap write.

Ports:
- clk, in, 1: single clock for all logic.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: one-cycle pulse that begins calibration of all lanes; ignored while busy.
- dly_done, in, NUM_CH: per-lane delay-settled flag from the lane delay sequencer.
- sample_valid, in, NUM_CH: per-lane strobe marking a scored sample this cycle.
- sample_ok, in, NUM_CH: per-lane flag, 1 = sample matched the training pattern; qualified by sample_valid.
- tap_out, out, NUM_CH*TAP_W: per-lane tap load value; lane i occupies bits [i*TAP_W +: TAP_W].
- busy, out, 1: calibration in progress.
- cal_done, out, 1: sticky; set when all lanes are finished, cleared by the next accepted start.
- ch_fail, out, NUM_CH: sticky per-lane failure flags, cleared by the next accepted start.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - all outputs to 0 (tap_out = 0 on every lane, busy = 0, cal_done = 0, ch_fail = 0);
  - FSM to IDLE and all internal counters to 0.
- Reset mid-sweep aborts immediately; no partial result is kept.
- FSM states:
  - IDLE: on start: busy=1, cal_done=0, ch_fail=0, ch=0, tap=0, go to SET_TAP.
  - SET_TAP: write tap to tap_out[ch]; load settle counter = SETTLE_IGN and timeout counter = 0; go to WAIT_RDY.
  - WAIT_RDY:
    - ignore dly_done[ch] until the settle counter reaches 0;
    - then dly_done[ch]=1 -> SAMPLE, with sample count and error count cleared;
    - timeout counter reaches TIMEOUT -> ch_fail[ch]=1, tap_out[ch]=0, go to NEXT_CH.
  - SAMPLE:
    - count cycles where sample_valid[ch]=1;
    - sample_valid with sample_ok=0 sets the error flag;
    - after SAMPLE_CNT valid samples, go to EVAL.
  - EVAL (1 cycle):
    - tap passes iff the error flag is clear;
    - pass: if run_len==0 then run_start=tap; run_len++; if run_len>best_len (strictly greater) then best_len=run_len and best_start=run_start;
    - fail: run_len=0;
    - if tap+TAP_STEP>TAP_MAX go to LOAD_CENTER, else tap+=TAP_STEP and go to SET_TAP.
  - LOAD_CENTER:
    - best_len==0: ch_fail[ch]=1, tap_out[ch]=0, go to NEXT_CH;
    - else tap_out[ch] = best_start + ((best_len-1)*TAP_STEP)>>1, truncated; go to WAIT_CENTER with settle and timeout counters reloaded.
  - WAIT_CENTER: same settle, dly_done and timeout rules as WAIT_RDY; done -> NEXT_CH; timeout -> ch_fail[ch]=1, tap_out[ch] keeps the centre value.
  - NEXT_CH: clear run_start, run_len, best_start, best_len and tap; ch==NUM_CH-1 -> DONE, else ch++ and go to SET_TAP.
  - DONE: busy=0, cal_done=1; go to IDLE.
- Arithmetic:
  - centre computed at TAP_W+8 bits, then truncated to TAP_W;
  - the centre cannot exceed TAP_MAX;
  - run_len and best_len are sized for TAP_MAX/TAP_STEP+1 sweep points.
- Lane isolation:
  - lanes other than ch hold tap_out unchanged;
  - their dly_done, sample_valid and sample_ok are ignored.
- Boundaries and ordering:
  - start while busy is ignored;
  - start in the same cycle as DONE is ignored (accepted once back in IDLE);
  - a passing window touching TAP_MAX is closed at the end of the sweep and still evaluated;
  - on equal-length windows, the lowest one wins.

Test Plan:
- Single window: NUM_CH=2, defaults; lane0 passes only taps 80..200 (16 points) -> tap_out[0]=140, ch_fail=00, cal_done=1.
- Two windows: lane0 passes 16..48 (5 points) and 304..400 (13 points) -> tap_out[0]=352.
- Tie and split window:
  - lane1 passes 8..40 and 200..232 (5 points each) -> tap_out[1]=24, first window wins;
  - lane0 window 80..200 with one bad sample at tap 96 -> windows 80..88 and 104..200 -> tap_out[0]=152.
- Failures:
  - lane1 sample_ok always 0 -> ch_fail=10, tap_out[1]=0, lane0 still centred;
  - dly_done[0] stuck 0 -> ch_fail[0]=1 after 4096+SETTLE_IGN cycles in WAIT_RDY, lane1 still calibrated.
- Control:
  - start pulsed mid-sweep -> no restart, result unchanged;
  - rst_n low mid-sweep -> all outputs 0 on the same edge;
  - second start after DONE -> cal_done and ch_fail cleared, then recomputed.

Source files
------------

// File: rtl/idelay_eye_cal.sv
// Multi-lane input-delay eye-centring controller: sweeps each lane's taps in turn,
// scores every point, and loads the centre of the longest contiguous passing window.
module idelay_eye_cal #(
    parameter int NUM_CH     = 4,
    parameter int TAP_W      = 9,
    parameter int TAP_MAX    = 511,
    parameter int TAP_STEP   = 8,
    parameter int SAMPLE_CNT = 256,
    parameter int SETTLE_IGN = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [NUM_CH-1:0]       dly_done,
    input  logic [NUM_CH-1:0]       sample_valid,
    input  logic [NUM_CH-1:0]       sample_ok,
    output logic [NUM_CH*TAP_W-1:0] tap_out,
    output logic                    busy,
    output logic                    cal_done,
    output logic [NUM_CH-1:0]       ch_fail
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int RUN_W = $clog2(TAP_MAX / TAP_STEP + 2);
    localparam int ST_W  = (SETTLE_IGN > 0) ? $clog2(SETTLE_IGN + 1) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int SMP_W = $clog2(SAMPLE_CNT + 1);
    localparam int CW    = TAP_W + 8;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SET_TAP, S_WAIT_RDY, S_SAMPLE, S_EVAL,
        S_LOAD_CENTER, S_WAIT_CENTER, S_NEXT_CH, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [CH_W-1:0]   ch;
    logic [TAP_W-1:0]  tap, run_start, best_start;
    logic [RUN_W-1:0]  run_len, best_len;
    logic [ST_W-1:0]   settle_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [SMP_W-1:0]  smp_cnt;
    logic              err_flag;

    logic              wait_st, settled, lane_rdy, tmo_hit, smp_vld, smp_last;
    logic              sweep_end, best_none;
    logic [TAP_W:0]    tap_sum;
    logic [RUN_W-1:0]  run_len_inc;
    logic [TAP_W-1:0]  centre;

    logic              accept, arm_wait, settle_dec, tmo_inc, smp_clr, lane_fail, tap_zero;

    always_comb begin
        wait_st     = (state == S_WAIT_RDY) || (state == S_WAIT_CENTER);
        settled     = (settle_cnt == '0);
        lane_rdy    = dly_done[ch];
        tmo_hit     = (tmo_cnt == TMO_W'(TIMEOUT - 1));
        smp_vld     = sample_valid[ch];
        smp_last    = smp_vld && (smp_cnt == SMP_W'(SAMPLE_CNT - 1));
        tap_sum     = {1'b0, tap} + (TAP_W+1)'(TAP_STEP);
        sweep_end   = tap_sum > (TAP_W+1)'(TAP_MAX);
        best_none   = (best_len == '0);
        run_len_inc = run_len + RUN_W'(1);
        // Half-width of the window added to its first tap; widened so the product cannot wrap.
        centre      = TAP_W'(CW'(best_start) +
                             (((CW'(best_len) - CW'(1)) * CW'(TAP_STEP)) >> 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:        if (start) state_nxt = S_SET_TAP;
            S_SET_TAP:     state_nxt = S_WAIT_RDY;
            S_WAIT_RDY: begin
                if (settled) begin
                    if (lane_rdy)     state_nxt = S_SAMPLE;
                    else if (tmo_hit) state_nxt = S_NEXT_CH;
                end
            end
            S_SAMPLE:      if (smp_last) state_nxt = S_EVAL;
            S_EVAL:        state_nxt = sweep_end ? S_LOAD_CENTER : S_SET_TAP;
            S_LOAD_CENTER: state_nxt = best_none ? S_NEXT_CH : S_WAIT_CENTER;
            S_WAIT_CENTER: if (settled && (lane_rdy || tmo_hit)) state_nxt = S_NEXT_CH;
            S_NEXT_CH:     state_nxt = (ch == LAST_CH) ? S_DONE : S_SET_TAP;
            S_DONE:        state_nxt = S_IDLE;
            default:       state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        accept     = (state == S_IDLE) && start;
        arm_wait   = (state == S_SET_TAP) || ((state == S_LOAD_CENTER) && !best_none);
        settle_dec = wait_st && !settled;
        tmo_inc    = wait_st && settled && !lane_rdy && !tmo_hit;
        smp_clr    = (state == S_WAIT_RDY) && settled && lane_rdy;
        lane_fail  = (wait_st && settled && !lane_rdy && tmo_hit) ||
                     ((state == S_LOAD_CENTER) && best_none);
        // A lane that timed out on its centre tap keeps that centre value.
        tap_zero   = lane_fail && (state != S_WAIT_CENTER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_out    <= '0;
            busy       <= 1'b0;
            cal_done   <= 1'b0;
            ch_fail    <= '0;
            ch         <= '0;
            tap        <= '0;
            run_start  <= '0;
            run_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
            settle_cnt <= '0;
            tmo_cnt    <= '0;
            smp_cnt    <= '0;
            err_flag   <= 1'b0;
        end else begin
            if (accept) begin
                busy     <= 1'b1;
                cal_done <= 1'b0;
                ch_fail  <= '0;
                ch       <= '0;
                tap      <= '0;
            end
            if (arm_wait) begin
                settle_cnt <= ST_W'(SETTLE_IGN);
                tmo_cnt    <= '0;
            end
            if (settle_dec) settle_cnt <= settle_cnt - ST_W'(1);
            if (tmo_inc)    tmo_cnt    <= tmo_cnt + TMO_W'(1);

            if (state == S_SET_TAP)
                tap_out[ch*TAP_W +: TAP_W] <= tap;
            if ((state == S_LOAD_CENTER) && !best_none)
                tap_out[ch*TAP_W +: TAP_W] <= centre;
            if (tap_zero)
                tap_out[ch*TAP_W +: TAP_W] <= '0;
            if (lane_fail)
                ch_fail[ch] <= 1'b1;

            if (smp_clr) begin
                smp_cnt  <= '0;
                err_flag <= 1'b0;
            end
            if ((state == S_SAMPLE) && smp_vld) begin
                smp_cnt <= smp_cnt + SMP_W'(1);
                if (!sample_ok[ch]) err_flag <= 1'b1;
            end

            if (state == S_EVAL) begin
                if (!err_flag) begin
                    if (run_len == '0) run_start <= tap;
                    run_len <= run_len_inc;
                    // Strictly greater, so the lowest of equal windows is retained.
                    if (run_len_inc > best_len) begin
                        best_len   <= run_len_inc;
                        best_start <= (run_len == '0) ? tap : run_start;
                    end
                end else begin
                    run_len <= '0;
                end
                if (!sweep_end) tap <= tap_sum[TAP_W-1:0];
            end

            if (state == S_NEXT_CH) begin
                run_start  <= '0;
                run_len    <= '0;
                best_start <= '0;
                best_len   <= '0;
                tap        <= '0;
                if (ch != LAST_CH) ch <= ch + CH_W'(1);
            end

            if (state == S_DONE) begin
                busy     <= 1'b0;
                cal_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_idelay_eye_cal.sv
// Directed bench for idelay_eye_cal: two lanes with a behavioural delay/pattern model
// whose pass windows are set per run; expected centres are hand-computed.
module tb_idelay_eye_cal;

    localparam int NCH = 2;
    localparam int TW  = 9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [NCH-1:0]    dly_done, sample_valid, sample_ok;
    logic [NCH*TW-1:0] tap_out;
    logic              busy, cal_done;
    logic [NCH-1:0]    ch_fail;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lo0[NCH], hi0[NCH], lo1[NCH], hi1[NCH], bad_tap[NCH];
    int lt[NCH];
    logic [NCH-1:0] stuck = '0;
    logic alt_vld = 1'b0;
    int n_cyc;

    idelay_eye_cal #(
        .NUM_CH(NCH), .TAP_W(TW), .TAP_MAX(511), .TAP_STEP(8),
        .SAMPLE_CNT(4), .SETTLE_IGN(2), .TIMEOUT(4096)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dly_done(dly_done), .sample_valid(sample_valid), .sample_ok(sample_ok),
        .tap_out(tap_out), .busy(busy), .cal_done(cal_done), .ch_fail(ch_fail)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < NCH; i++) lt[i] = int'(tap_out[i*TW +: TW]);
    end

    // Lane model: pass iff the lane's current tap lies in one of its windows;
    // one sample in four fails at bad_tap; invalid cycles carry ok=0.
    always_comb begin
        dly_done     = '0;
        sample_valid = '0;
        sample_ok    = '0;
        for (int i = 0; i < NCH; i++) begin
            dly_done[i]     = !stuck[i];
            sample_valid[i] = alt_vld ? cyc[0] : 1'b1;
            sample_ok[i]    = sample_valid[i] &&
                              ((lt[i] >= lo0[i] && lt[i] <= hi0[i]) ||
                               (lt[i] >= lo1[i] && lt[i] <= hi1[i])) &&
                              !(lt[i] == bad_tap[i] && cyc[1:0] == 2'd0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_lane(input int i, input int a0, input int b0, input int a1, input int b1,
                            input int bad);
        lo0[i] = a0; hi0[i] = b0; lo1[i] = a1; hi1[i] = b1; bad_tap[i] = bad;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (cal_done !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(tag, cal_done, 1);
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) set_lane(i, 1000, 0, 1000, 0, 1000);
        repeat (3) @(negedge clk);
        check("rst_tap", tap_out, 0);
        check("rst_busy", busy, 0);
        check("rst_cal_done", cal_done, 0);
        check("rst_ch_fail", ch_fail, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single window on lane0, tied windows on lane1, stray start mid-sweep
        set_lane(0, 80, 200, 1000, 0, 1000);
        set_lane(1, 8, 40, 200, 232, 1000);
        pulse_start();
        check("busy_after_start", busy, 1);
        repeat (500) @(negedge clk);
        check("busy_mid", busy, 1);
        pulse_start();
        wait_done("a_done", n_cyc);
        check("a_no_restart", (n_cyc < 800) ? 1 : 0, 1);
        check("a_tap0", lt[0], 140);
        check("a_tap1_tie", lt[1], 24);
        check("a_ch_fail", ch_fail, 0);
        check("a_busy", busy, 0);

        // Two windows on lane0 with sparse valid strobes, lane1 never passes
        set_lane(0, 16, 48, 304, 400, 1000);
        set_lane(1, 1000, 0, 1000, 0, 1000);
        alt_vld = 1'b1;
        repeat (3) @(negedge clk);
        pulse_start();
        check("b_cal_done_clr", cal_done, 0);
        wait_done("b_done", n_cyc);
        check("b_tap0", lt[0], 352);
        check("b_tap1", lt[1], 0);
        check("b_ch_fail", ch_fail, 2'b10);

        // Split window on lane0, window touching TAP_MAX on lane1
        alt_vld = 1'b0;
        set_lane(0, 80, 200, 1000, 0, 96);
        set_lane(1, 480, 504, 1000, 0, 1000);
        pulse_start();
        check("c_ch_fail_clr", ch_fail, 0);
        wait_done("c_done", n_cyc);
        check("c_tap0_split", lt[0], 152);
        check("c_tap1_edge", lt[1], 492);
        check("c_ch_fail", ch_fail, 0);

        // Lane0 never settles: timeout after TIMEOUT+SETTLE_IGN cycles in WAIT_RDY
        stuck = 2'b01;
        set_lane(1, 80, 200, 1000, 0, 1000);
        pulse_start();
        repeat (4094) @(negedge clk);
        check("d_no_early_tmo", ch_fail, 0);
        repeat (6) @(negedge clk);
        check("d_tmo_flag", ch_fail, 2'b01);
        wait_done("d_done", n_cyc);
        check("d_ch_fail", ch_fail, 2'b01);
        check("d_tap0", lt[0], 0);
        check("d_tap1", lt[1], 140);
        stuck = 2'b00;

        // Asynchronous reset mid-sweep, then a clean recalibration
        set_lane(0, 80, 200, 1000, 0, 1000);
        set_lane(1, 8, 40, 200, 232, 1000);
        pulse_start();
        repeat (300) @(negedge clk);
        check("e_busy_mid", busy, 1);
        check("e_tap0_moving", (lt[0] != 0) ? 1 : 0, 1);
        #2 rst_n = 1'b0;
        #1;
        check("e_rst_tap", tap_out, 0);
        check("e_rst_busy", busy, 0);
        check("e_rst_cal_done", cal_done, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("e_idle_busy", busy, 0);
        pulse_start();
        wait_done("f_done", n_cyc);
        check("f_tap0", lt[0], 140);
        check("f_tap1", lt[1], 24);
        check("f_ch_fail", ch_fail, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
